branch_predict_ctrl: RTL and testbench

- Branch prediction and redirect controller between the IF-stage PC logic and the EX-stage branch resolution (PcSel/BrPC).
- Holds a direct-mapped branch target table with 2-bit saturating counters.
- IF: supplies a predicted next PC. EX: compares the actual outcome with the prediction carried down the pipe, then drives redirect and flush on a mismatch and trains the table.
- Keeps saturating branch and mispredict counters for performance readout.

---
 rtl/branch_predict_ctrl_pkg.sv | 31 +++
 rtl/branch_predict_ctrl_bp_table.sv | 70 +++++++
 rtl/branch_predict_ctrl.sv | 95 +++++++++
 tb/tb_branch_predict_ctrl.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/branch_predict_ctrl_pkg.sv
// Shared types and constants for the branch predictor: FSM states, table entry
// layout and 2-bit saturating counter encodings.
package branch_predict_ctrl_pkg;

  typedef enum logic {
    NORMAL  = 1'b0,
    RECOVER = 1'b1
  } bp_state_e;

  // Tags are stored zero-extended to a fixed width so the entry type does not
  // depend on module parameters.
  localparam int unsigned TAG_MAX_W = 32;

  typedef struct packed {
    logic                 valid;
    logic [TAG_MAX_W-1:0] tag;
    logic                 is_jump;
    logic [1:0]           ctr;
    logic [31:0]          target;
  } bp_entry_t;

  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_MAX = 2'b11;

  function automatic logic [1:0] ctr_update(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == CTR_MAX) ? ctr : ctr + 2'd1;
    else       return (ctr == 2'b00)   ? ctr : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/branch_predict_ctrl_bp_table.sv
// Direct-mapped branch target table: one combinational lookup port producing
// the prediction, one write port applying allocate/train on resolution.
module bp_table
  import branch_predict_ctrl_pkg::*;
#(
  parameter int unsigned PC_W    = 9,
  parameter int unsigned ENTRIES = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [PC_W-1:0] rd_pc_i,
  output logic            rd_taken_o,
  output logic [31:0]     rd_target_o,
  input  logic            wr_en_i,
  input  logic [PC_W-1:0] wr_pc_i,
  input  logic            wr_taken_i,
  input  logic            wr_jump_i,
  input  logic [31:0]     wr_target_i
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);

  bp_entry_t mem_q [ENTRIES];

  logic [IDX_W-1:0]     rd_idx, wr_idx;
  logic [TAG_MAX_W-1:0] rd_tag, wr_tag;
  bp_entry_t            rd_entry, wr_cur, wr_nxt;
  logic                 rd_hit;
  logic                 unused_pc_lsbs;

  assign rd_idx = rd_pc_i[IDX_W+1:2];
  assign wr_idx = wr_pc_i[IDX_W+1:2];
  assign rd_tag = TAG_MAX_W'(rd_pc_i[PC_W-1:IDX_W+2]);
  assign wr_tag = TAG_MAX_W'(wr_pc_i[PC_W-1:IDX_W+2]);
  assign unused_pc_lsbs = ^{rd_pc_i[1:0], wr_pc_i[1:0]};

  always_comb begin
    rd_entry    = mem_q[rd_idx];
    rd_hit      = rd_entry.valid && (rd_entry.tag == rd_tag);
    rd_taken_o  = rd_hit && (rd_entry.is_jump || rd_entry.ctr[1]);
    rd_target_o = rd_hit ? rd_entry.target : '0;
  end

  always_comb begin
    wr_cur = mem_q[wr_idx];
    wr_nxt = wr_cur;
    if (!wr_cur.valid || (wr_cur.tag != wr_tag)) begin
      wr_nxt.valid   = 1'b1;
      wr_nxt.tag     = wr_tag;
      wr_nxt.is_jump = wr_jump_i;
      wr_nxt.ctr     = wr_taken_i ? CTR_WT : CTR_WNT;
      wr_nxt.target  = wr_target_i;
    end else begin
      wr_nxt.is_jump = wr_jump_i;
      wr_nxt.ctr     = ctr_update(wr_cur.ctr, wr_taken_i);
      if (wr_taken_i) wr_nxt.target = wr_target_i;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        mem_q[i] <= '{valid: 1'b0, tag: '0, is_jump: 1'b0, ctr: CTR_WNT, target: '0};
      end
    end else if (wr_en_i) begin
      mem_q[wr_idx] <= wr_nxt;
    end
  end

endmodule

// File: rtl/branch_predict_ctrl.sv
// Branch prediction / redirect controller: IF-side lookup, EX-side compare with
// same-cycle redirect and flush, one-cycle recovery window, statistics counters.
module branch_predict_ctrl
  import branch_predict_ctrl_pkg::*;
#(
  parameter int unsigned PC_W    = 9,
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PC_W-1:0]  if_pc,
  output logic             pred_taken,
  output logic [31:0]      pred_target,
  input  logic             ex_valid,
  input  logic             ex_branch,
  input  logic             ex_jump,
  input  logic [PC_W-1:0]  ex_pc,
  input  logic             ex_taken,
  input  logic [31:0]      ex_target,
  input  logic             ex_pred_taken,
  input  logic [31:0]      ex_pred_target,
  output logic             redirect,
  output logic [31:0]      redirect_pc,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mispred_count
);

  bp_state_e        state_q, state_d;
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0] mis_cnt_q, mis_cnt_d;
  logic             resolve, mispredict;

  bp_table #(
    .PC_W    (PC_W),
    .ENTRIES (ENTRIES)
  ) u_table (
    .clk         (clk),
    .reset       (reset),
    .rd_pc_i     (if_pc),
    .rd_taken_o  (pred_taken),
    .rd_target_o (pred_target),
    .wr_en_i     (resolve),
    .wr_pc_i     (ex_pc),
    .wr_taken_i  (ex_taken),
    .wr_jump_i   (ex_jump),
    .wr_target_i (ex_target)
  );

  // Gating on reset keeps the combinational redirect path quiet while reset is held.
  always_comb begin
    resolve    = !reset && ex_valid && (ex_branch || ex_jump) && (state_q == NORMAL);
    mispredict = resolve && ((ex_taken != ex_pred_taken) ||
                             (ex_taken && (ex_target != ex_pred_target)));
  end

  always_comb begin
    redirect    = mispredict;
    flush_if_id = mispredict;
    flush_id_ex = mispredict;
    redirect_pc = '0;
    if (mispredict) redirect_pc = ex_taken ? ex_target : 32'(ex_pc) + 32'd4;
  end

  always_comb begin
    state_d   = state_q;
    br_cnt_d  = br_cnt_q;
    mis_cnt_d = mis_cnt_q;
    unique case (state_q)
      NORMAL:  if (mispredict) state_d = RECOVER;
      RECOVER: state_d = NORMAL;
      default: state_d = NORMAL;
    endcase
    if (resolve && (br_cnt_q != '1))     br_cnt_d  = br_cnt_q + 1'b1;
    if (mispredict && (mis_cnt_q != '1)) mis_cnt_d = mis_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= NORMAL;
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      br_cnt_q  <= br_cnt_d;
      mis_cnt_q <= mis_cnt_d;
    end
  end

  assign br_count      = br_cnt_q;
  assign mispred_count = mis_cnt_q;

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Scoreboard bench for branch_predict_ctrl: directed vectors push expected
// outputs; a negedge monitor pops and compares.
module tb_branch_predict_ctrl;

  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [8:0]       if_pc = '0;
  logic             pred_taken;
  logic [31:0]      pred_target;
  logic             ex_valid = 1'b0, ex_branch = 1'b0, ex_jump = 1'b0;
  logic [8:0]       ex_pc = '0;
  logic             ex_taken = 1'b0;
  logic [31:0]      ex_target = '0;
  logic             ex_pred_taken = 1'b0;
  logic [31:0]      ex_pred_target = '0;
  logic             redirect;
  logic [31:0]      redirect_pc;
  logic             flush_if_id, flush_id_ex;
  logic [CNT_W-1:0] br_count, mispred_count;

  branch_predict_ctrl #(
    .PC_W    (9),
    .ENTRIES (16),
    .CNT_W   (CNT_W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .if_pc          (if_pc),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .ex_valid       (ex_valid),
    .ex_branch      (ex_branch),
    .ex_jump        (ex_jump),
    .ex_pc          (ex_pc),
    .ex_taken       (ex_taken),
    .ex_target      (ex_target),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_target (ex_pred_target),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .flush_if_id    (flush_if_id),
    .flush_id_ex    (flush_id_ex),
    .br_count       (br_count),
    .mispred_count  (mispred_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string            name;
    logic             pt;
    logic [31:0]      ptg;
    logic             rd;
    logic [31:0]      rpc;
    logic [CNT_W-1:0] br;
    logic [CNT_W-1:0] mis;
  } exp_t;

  exp_t             sb[$];
  int               n_tests = 0;
  int               n_fail  = 0;
  logic [CNT_W-1:0] exp_br  = '0;
  logic [CNT_W-1:0] exp_mis = '0;

  task automatic check(input string name, input string field,
                       input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got 0x%0h expected 0x%0h", name, field, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      check(e.name, "pred_taken",    32'(pred_taken),    32'(e.pt));
      check(e.name, "pred_target",   pred_target,        e.ptg);
      check(e.name, "redirect",      32'(redirect),      32'(e.rd));
      check(e.name, "redirect_pc",   redirect_pc,        e.rpc);
      check(e.name, "flush_if_id",   32'(flush_if_id),   32'(e.rd));
      check(e.name, "flush_id_ex",   32'(flush_id_ex),   32'(e.rd));
      check(e.name, "br_count",      32'(br_count),      32'(e.br));
      check(e.name, "mispred_count", 32'(mispred_count), 32'(e.mis));
    end
  end

  // One cycle: drive inputs after the edge, queue the expected response, then
  // advance the saturating count model for the edge that follows.
  task automatic step(input string name, input logic rst, input logic [8:0] ipc,
                      input logic v, input logic b, input logic j, input logic [8:0] pc,
                      input logic tk, input logic [31:0] tgt,
                      input logic ptk, input logic [31:0] ptgt,
                      input logic e_pt, input logic [31:0] e_ptg,
                      input logic e_rd, input logic [31:0] e_rpc, input logic e_res);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst; if_pc = ipc;
    ex_valid = v; ex_branch = b; ex_jump = j; ex_pc = pc;
    ex_taken = tk; ex_target = tgt; ex_pred_taken = ptk; ex_pred_target = ptgt;
    if (rst) begin
      exp_br = '0;
      exp_mis = '0;
    end
    e.name = name; e.pt = e_pt; e.ptg = e_ptg; e.rd = e_rd; e.rpc = e_rpc;
    e.br = exp_br; e.mis = exp_mis;
    sb.push_back(e);
    if (!rst) begin
      if (e_res && (exp_br != '1)) exp_br = exp_br + 1'b1;
      if (e_rd && (exp_mis != '1)) exp_mis = exp_mis + 1'b1;
    end
  endtask

  task automatic idle(input string name, input logic [8:0] ipc,
                      input logic e_pt, input logic [31:0] e_ptg);
    step(name, 1'b0, ipc, 1'b0, 1'b0, 1'b0, 9'h0, 1'b0, 32'h0, 1'b0, 32'h0,
         e_pt, e_ptg, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    //   name            rst ipc     v  b  j  pc      tk tgt      ptk ptgt     ept eptg     erd erpc    res
    step("reset",         1, 9'h010, 0, 0, 0, 9'h000, 0, 32'h00,  0, 32'h00,  0, 32'h00,  0, 32'h00,  0);
    idle("post_reset", 9'h010, 0, 32'h0);
    step("mis_taken",     0, 9'h010, 1, 1, 0, 9'h010, 1, 32'h40,  0, 32'h00,  0, 32'h00,  1, 32'h40,  1);
    idle("pred_after_alloc", 9'h010, 1, 32'h40);
    step("mis_nottaken",  0, 9'h010, 1, 1, 0, 9'h010, 0, 32'h40,  1, 32'h40,  1, 32'h40,  1, 32'h014, 1);
    step("recover_supp",  0, 9'h010, 1, 1, 0, 9'h010, 1, 32'h80,  0, 32'h00,  0, 32'h40,  0, 32'h00,  0);
    step("mis_t_plus2",   0, 9'h010, 1, 1, 0, 9'h010, 1, 32'h80,  0, 32'h00,  0, 32'h40,  1, 32'h80,  1);
    idle("pred_retrained", 9'h010, 1, 32'h80);
    step("correct_pred",  0, 9'h010, 1, 1, 0, 9'h010, 1, 32'h80,  1, 32'h80,  1, 32'h80,  0, 32'h00,  1);
    step("wrong_target",  0, 9'h010, 1, 1, 0, 9'h010, 1, 32'h90,  1, 32'h80,  1, 32'h80,  1, 32'h90,  1);
    idle("pred_new_tgt", 9'h010, 1, 32'h90);
    step("alias_jump",    0, 9'h010, 1, 0, 1, 9'h050, 1, 32'h100, 1, 32'h100, 1, 32'h90,  0, 32'h00,  1);
    idle("alias_miss", 9'h010, 0, 32'h0);
    idle("alias_hit",  9'h050, 1, 32'h100);
    step("ex_invalid",    0, 9'h050, 0, 1, 0, 9'h010, 1, 32'h80,  0, 32'h00,  1, 32'h100, 0, 32'h00,  0);
    step("nt_pc_plus4",   0, 9'h050, 1, 1, 0, 9'h1FC, 0, 32'h44,  1, 32'h10,  1, 32'h100, 1, 32'h200, 1);
    idle("nt_alloc", 9'h1FC, 0, 32'h44);
    for (int k = 0; k < 12; k++) begin
      step("sat_mis",     0, 9'h050, 1, 1, 0, 9'h020, 1, 32'h60,  0, 32'h00,  1, 32'h100, 1, 32'h60,  1);
      idle("sat_rec", 9'h050, 1, 32'h100);
    end
    step("sat_hold",      0, 9'h050, 1, 1, 0, 9'h020, 1, 32'h60,  0, 32'h00,  1, 32'h100, 1, 32'h60,  1);
    step("reset_in_rec",  1, 9'h050, 1, 1, 0, 9'h020, 1, 32'h60,  0, 32'h00,  0, 32'h00,  0, 32'h00,  0);
    step("normal_after",  0, 9'h050, 1, 1, 0, 9'h020, 1, 32'h60,  0, 32'h00,  0, 32'h00,  1, 32'h60,  1);
    idle("counts_after", 9'h050, 0, 32'h0);
    @(negedge clk);
    #1;
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
